// File: rtl/rvmyth_run_ctrl_pkg.sv
// rtl/rvmyth_run_ctrl_pkg.sv - shared types, defaults and request decode for rvmyth run control
package rvmyth_ctrl_pkg;

    localparam int OUT_W_DEF = 10;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_HALT     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    // Highest-priority request wins; lower ones in the same cycle are dropped.
    typedef enum logic [2:0] {
        REQ_NONE    = 3'd0,
        REQ_START   = 3'd1,
        REQ_STEP    = 3'd2,
        REQ_HALT    = 3'd3,
        REQ_RESTART = 3'd4
    } req_e;

    function automatic req_e decode_req(input logic restart, input logic halt,
                                        input logic step, input logic start);
        if (restart)    return REQ_RESTART;
        else if (halt)  return REQ_HALT;
        else if (step)  return REQ_STEP;
        else if (start) return REQ_START;
        else            return REQ_NONE;
    endfunction

endpackage

// File: rtl/rvmyth_run_ctrl_if.sv
// rtl/rvmyth_run_ctrl_if.sv - request and status bundle between host and run controller
interface rvmyth_run_ctrl_if #(
    parameter int OUT_W = 10,
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             halt;
    logic             step;
    logic             restart;
    logic [OUT_W-1:0] core_out;
    logic [OUT_W-1:0] expect_val;
    logic             expect_en;
    logic             core_reset;
    logic             clk_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [OUT_W-1:0] out_sample;

    modport master (
        output start, halt, step, restart, core_out, expect_val, expect_en,
        input  core_reset, clk_en, busy, done, pass, timeout, cycle_cnt, out_sample
    );

    modport slave (
        input  start, halt, step, restart, core_out, expect_val, expect_en,
        output core_reset, clk_en, busy, done, pass, timeout, cycle_cnt, out_sample
    );
endinterface

// File: rtl/rvmyth_run_ctrl_sat_cnt.sv
// rtl/rvmyth_run_ctrl_sat_cnt.sv - saturating up-counter with synchronous clear and enable
module rvmyth_ctrl_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    // Clear beats enable; counting stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + W'(1);
    end
endmodule

// File: rtl/rvmyth_run_ctrl.sv
// rtl/rvmyth_run_ctrl.sv - reset hold, start/halt/step sequencing and run completion for rvmyth
module rvmyth_run_ctrl
    import rvmyth_ctrl_pkg::*;
#(
    parameter int OUT_W      = OUT_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RST_CYCLES = 5,
    parameter int TIMEOUT    = 1000
) (
    input  logic          clk_pri,
    input  logic          reset,
    rvmyth_run_ctrl_if.slave bus
);
    state_e           state_q, state_d;
    req_e             req;
    logic [7:0]       hold_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic             match, hold_done, hold_clr, hold_en, cnt_en, cnt_clr;
    logic             pass_d, timeout_d;
    logic             core_reset_q, clk_en_q, busy_q, done_q, pass_q, timeout_q;
    logic [OUT_W-1:0] out_sample_q;

    assign req       = decode_req(bus.restart, bus.halt, bus.step, bus.start);
    assign match     = bus.expect_en && (bus.core_out == bus.expect_val);
    assign hold_done = (hold_cnt == 8'(RST_CYCLES - 1));

    // Hold counter only runs while in the reset hold and restarts from zero on every entry.
    assign hold_en  = (state_q == ST_RST_HOLD);
    assign hold_clr = (req == REQ_RESTART) || (state_q != ST_RST_HOLD);

    // Executed cycles are exactly those where the gate is open outside the reset hold.
    assign cnt_en  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign cnt_clr = (req == REQ_RESTART);

    rvmyth_ctrl_sat_cnt #(.W(8)) u_hold_cnt (
        .clk   (clk_pri),
        .reset (reset),
        .clr   (hold_clr),
        .en    (hold_en),
        .q     (hold_cnt)
    );

    rvmyth_ctrl_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk_pri),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt_q)
    );

    // Next-state and sticky result flags; restart overrides every state.
    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        if (req == REQ_RESTART) begin
            state_d   = ST_RST_HOLD;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_RST_HOLD: if (hold_done) state_d = ST_HALT;
                ST_HALT: begin
                    if (req == REQ_STEP)       state_d = ST_STEP;
                    else if (req == REQ_START) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (req == REQ_HALT) begin
                        state_d = ST_HALT;
                    end else if (match) begin
                        state_d = ST_FINISH;
                        pass_d  = 1'b1;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d   = ST_FINISH;
                        timeout_d = 1'b1;
                    end
                end
                ST_STEP:   state_d = ST_HALT;
                ST_FINISH: state_d = ST_FINISH;
                default:   state_d = ST_RST_HOLD;
            endcase
        end
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk_pri) begin
        if (reset) begin
            state_q      <= ST_RST_HOLD;
            core_reset_q <= 1'b1;
            clk_en_q     <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            out_sample_q <= '0;
        end else begin
            state_q      <= state_d;
            core_reset_q <= (state_d == ST_RST_HOLD);
            clk_en_q     <= (state_d == ST_RST_HOLD) || (state_d == ST_RUN) || (state_d == ST_STEP);
            busy_q       <= (state_d == ST_RST_HOLD) || (state_d == ST_RUN) || (state_d == ST_STEP);
            done_q       <= (state_d == ST_FINISH);
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            if (clk_en_q)
                out_sample_q <= bus.core_out;
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.clk_en     = clk_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycle_cnt  = cnt_q;
    assign bus.out_sample = out_sample_q;
endmodule

// File: tb/tb_rvmyth_run_ctrl.sv
// tb/tb_rvmyth_run_ctrl.sv - directed self-checking bench for rvmyth_run_ctrl
module tb_rvmyth_run_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    rvmyth_run_ctrl_if #(.OUT_W(10), .CNT_W(16)) bus ();

    rvmyth_run_ctrl dut (
        .clk_pri (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_hold(output int n);
        n = 0;
        while (bus.core_reset && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic restart_and_settle();
        int n;
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        wait_hold(n);
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL settle_hold_len got=%0d want=5", n);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.core_reset, bus.clk_en, bus.busy, bus.done, bus.pass, bus.timeout} !== 6'b111000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=111000",
                     {bus.core_reset, bus.clk_en, bus.busy, bus.done, bus.pass, bus.timeout});
        end
        total++;
        if (bus.cycle_cnt !== 16'd0 || bus.out_sample !== 10'd0) begin
            bad++;
            $display("FAIL reset_counts got cnt=%0d smp=%0d want 0 0", bus.cycle_cnt, bus.out_sample);
        end
        reset = 1'b0;
        wait_hold(n);
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL reset_hold_len got=%0d want=5", n);
        end
        total++;
        if ({bus.core_reset, bus.clk_en, bus.busy} !== 3'b000 || bus.cycle_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_to_halt got rst/en/busy=%b cnt=%0d want 000 0",
                     {bus.core_reset, bus.clk_en, bus.busy}, bus.cycle_cnt);
        end
    endtask

    task automatic test_step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        bus.core_out = 10'd7;
        total++;
        if (bus.clk_en !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL step_open got en=%b busy=%b want 1 1", bus.clk_en, bus.busy);
        end
        tick();
        total++;
        if (bus.clk_en !== 1'b0 || bus.cycle_cnt !== 16'd1 || bus.out_sample !== 10'd7) begin
            bad++;
            $display("FAIL step_close got en=%b cnt=%0d smp=%0d want 0 1 7",
                     bus.clk_en, bus.cycle_cnt, bus.out_sample);
        end
        tick();
        total++;
        if (bus.clk_en !== 1'b0) begin
            bad++;
            $display("FAIL step_once got en=%b want 0", bus.clk_en);
        end
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            tick();
        end
        total++;
        if (bus.cycle_cnt !== 16'd4 || bus.clk_en !== 1'b0) begin
            bad++;
            $display("FAIL step_four got cnt=%0d en=%b want 4 0", bus.cycle_cnt, bus.clk_en);
        end
    endtask

    task automatic test_run_match();
        int n;
        restart_and_settle();
        bus.expect_en  = 1'b1;
        bus.expect_val = 10'd45;
        bus.core_out   = 10'd0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 60) begin
            n++;
            bus.core_out = 10'(8 + n);
            tick();
        end
        total++;
        if (n !== 37) begin
            bad++;
            $display("FAIL match_cycle got=%0d want=37", n);
        end
        total++;
        if ({bus.done, bus.pass, bus.timeout, bus.clk_en} !== 4'b1100) begin
            bad++;
            $display("FAIL match_flags got=%b want=1100", {bus.done, bus.pass, bus.timeout, bus.clk_en});
        end
        total++;
        if (bus.cycle_cnt !== 16'd37 || bus.out_sample !== 10'd45) begin
            bad++;
            $display("FAIL match_cnt got cnt=%0d smp=%0d want 37 45", bus.cycle_cnt, bus.out_sample);
        end
        bus.expect_en = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        restart_and_settle();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.clk_en && n < 1100) begin
            n++;
            tick();
        end
        total++;
        if (n !== 1000) begin
            bad++;
            $display("FAIL timeout_len got=%0d want=1000", n);
        end
        total++;
        if ({bus.done, bus.timeout, bus.pass} !== 3'b110 || bus.cycle_cnt !== 16'd1000) begin
            bad++;
            $display("FAIL timeout_flags got dtp=%b cnt=%0d want 110 1000",
                     {bus.done, bus.timeout, bus.pass}, bus.cycle_cnt);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.step  = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        total++;
        if (bus.clk_en !== 1'b0 || bus.done !== 1'b1 || bus.cycle_cnt !== 16'd1000) begin
            bad++;
            $display("FAIL finish_ignores got en=%b done=%b cnt=%0d want 0 1 1000",
                     bus.clk_en, bus.done, bus.cycle_cnt);
        end
    endtask

    task automatic test_restart();
        int n;
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        total++;
        if ({bus.done, bus.pass, bus.timeout, bus.core_reset, bus.clk_en} !== 5'b00011 ||
            bus.cycle_cnt !== 16'd0) begin
            bad++;
            $display("FAIL restart_finish got dpt/rst/en=%b cnt=%0d want 00011 0",
                     {bus.done, bus.pass, bus.timeout, bus.core_reset, bus.clk_en}, bus.cycle_cnt);
        end
        wait_hold(n);
        bus.core_out = 10'h155;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        total++;
        if (bus.cycle_cnt !== 16'd500) begin
            bad++;
            $display("FAIL run_500 got=%0d want=500", bus.cycle_cnt);
        end
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        total++;
        if (bus.core_reset !== 1'b1 || bus.clk_en !== 1'b1 || bus.cycle_cnt !== 16'd0) begin
            bad++;
            $display("FAIL restart_run got rst=%b en=%b cnt=%0d want 1 1 0",
                     bus.core_reset, bus.clk_en, bus.cycle_cnt);
        end
        tick();
        tick();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        wait_hold(n);
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL restart_hold_len got=%0d want=5", n);
        end
        total++;
        if ({bus.done, bus.pass, bus.timeout, bus.clk_en, bus.busy} !== 5'b00000 ||
            bus.cycle_cnt !== 16'd0 || bus.out_sample !== 10'h155) begin
            bad++;
            $display("FAIL restart_state got flags=%b cnt=%0d smp=%h want 00000 0 155",
                     {bus.done, bus.pass, bus.timeout, bus.clk_en, bus.busy}, bus.cycle_cnt, bus.out_sample);
        end
    endtask

    task automatic test_halt_resume();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        total++;
        if (bus.cycle_cnt !== 16'd20 || bus.clk_en !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL halt_run got cnt=%0d en=%b busy=%b want 20 0 0",
                     bus.cycle_cnt, bus.clk_en, bus.busy);
        end
        bus.start = 1'b1;
        bus.step  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.step  = 1'b0;
        total++;
        if (bus.clk_en !== 1'b1) begin
            bad++;
            $display("FAIL collide_open got en=%b want 1", bus.clk_en);
        end
        tick();
        tick();
        total++;
        if (bus.cycle_cnt !== 16'd21 || bus.clk_en !== 1'b0) begin
            bad++;
            $display("FAIL collide_step got cnt=%0d en=%b want 21 0", bus.cycle_cnt, bus.clk_en);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.halt       = 1'b0;
        bus.step       = 1'b0;
        bus.restart    = 1'b0;
        bus.core_out   = 10'd0;
        bus.expect_val = 10'd0;
        bus.expect_en  = 1'b0;
        @(negedge clk);
        test_reset();
        test_step();
        test_run_match();
        test_timeout();
        test_restart();
        test_halt_resume();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rvmyth_run_ctrl.md
Name: rvmyth_run_ctrl

Overview:
- Run-control sequencer for the rvmyth core.
- Owns the core's reset and the enable of its clock gate on clk_pri.
- Holds the core in reset for a fixed number of clocked cycles, then lets software or the bench start, halt or single-step the core.
- Ends a run either on a match of the core's 10-bit OUT against an expected value, or on a cycle timeout.

Parameters:
- OUT_W, 10, width of the core OUT bus.
- CNT_W, 16, width of the executed-cycle counter.
- RST_CYCLES, 5, number of cycles core_reset is held with the clock running (1..255).
- TIMEOUT, 1000, number of executed cycles after which a run is aborted (must be < 2^CNT_W).

Ports:
- clk_pri  in  1  primary clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin free-running execution.
- halt  in  1  pulse: stop the clock gate.
- step  in  1  pulse: execute exactly one core cycle.
- restart  in  1  pulse: re-enter the reset hold from any state.
- core_out  in  OUT_W  core OUT bus.
- expect_val  in  OUT_W  expected result value.
- expect_en  in  1  enables the match check.
- core_reset  out  1  reset to rvmyth.
- clk_en  out  1  enable to the clock gate.
- busy  out  1  high in RST_HOLD, RUN and STEP.
- done  out  1  sticky: run finished.
- pass  out  1  sticky: finished on match.
- timeout  out  1  sticky: finished on TIMEOUT.
- cycle_cnt  out  CNT_W  executed (clk_en=1) cycles since the last reset hold.
- out_sample  out  OUT_W  core_out captured on every enabled cycle.

Behaviour:
- Clocking and reset: all outputs are registered. Reset is synchronous and active-high; the clock is clk_pri.
- Reset values: state=RST_HOLD, core_reset=1, clk_en=1, busy=1, done=0, pass=0, timeout=0, cycle_cnt=0, out_sample=0. The hold counter is 0.
- States: RST_HOLD, HALT, RUN, STEP, FINISH.
- RST_HOLD:
  - core_reset=1 and clk_en=1, because the core's reset is synchronous and needs clock edges.
  - The hold counter increments each cycle. Once RST_CYCLES cycles have elapsed in RST_HOLD, next state is HALT with core_reset=0, clk_en=0.
  - cycle_cnt does not count in this state.
- HALT:
  - clk_en=0, busy=0.
  - Request priority: restart > halt > step > start. halt is a no-op here.
  - step -> STEP; start -> RUN.
  - A registered response means a request in cycle t gives clk_en=1 in cycle t+1.
- RUN:
  - clk_en=1. cycle_cnt increments every cycle.
  - halt -> HALT, so clk_en=0 from t+1.
  - Else if expect_en and core_out==expect_val -> FINISH with pass=1.
  - Else if cycle_cnt==TIMEOUT-1 -> FINISH with timeout=1. cycle_cnt ends at exactly TIMEOUT.
  - When a match and the timeout occur in the same cycle, the match wins: pass=1, timeout=0.
- STEP:
  - clk_en=1 for exactly one cycle. cycle_cnt increments by 1, then the state returns to HALT.
  - Requests other than restart are ignored while in STEP.
  - The match check is not performed in STEP.
- FINISH:
  - clk_en=0, done=1. pass and timeout hold their values.
  - start, step and halt are ignored; only restart leaves this state.
- restart, from any state including mid-RST_HOLD:
  - Next state is RST_HOLD with core_reset=1 and clk_en=1.
  - The hold counter, cycle_cnt, done, pass and timeout are cleared.
  - out_sample is retained.
- out_sample: loads core_out on every cycle where clk_en is currently 1, including RST_HOLD. It is otherwise held.
- cycle_cnt saturates at 2^CNT_W-1; it never wraps.
- Simultaneous start and step in HALT -> STEP.

Decomposition:
- Package rvmyth_ctrl_pkg holds:
  - the state enum (5 states, 3-bit encoding);
  - the OUT_W and CNT_W defaults;
  - the request priority encoding.
- Sub-module rvmyth_ctrl_sat_cnt: a saturating counter with clear and enable, instanced twice:
  - for the hold counter (8-bit);
  - for cycle_cnt (CNT_W).
- The FSM and the flags stay in the top.

Test Plan:
- Reset sequence: reset high for 2 cycles, then low -> core_reset=1 and clk_en=1 for exactly 5 cycles, then core_reset=0, clk_en=0, busy=0, cycle_cnt=0.
- Single step: in HALT, step pulse at cycle t -> clk_en=1 only at t+1, cycle_cnt=1, back in HALT at t+2. Three further steps -> cycle_cnt=4.
- Run to match: expect_en=1, expect_val=10'd45, start, core_out ramps and reaches 45 at enabled cycle 37 -> next cycle done=1, pass=1, timeout=0, clk_en=0, cycle_cnt=37.
- Timeout: expect_en=0, start -> clk_en high for exactly 1000 cycles, then done=1, timeout=1, pass=0, cycle_cnt=1000. A following start or step leaves clk_en=0.
- Halt and resume plus collision: start, halt after 20 cycles -> cycle_cnt=20, clk_en=0. Then start and step in the same cycle -> a single step, cycle_cnt=21.
- Restart mid-operation: restart during RUN at cycle_cnt=500, and again during the 3rd RST_HOLD cycle -> each time the 5-cycle hold begins afresh. Flags and cycle_cnt=0, out_sample unchanged.
